psum_accumulator: RTL and testbench

- Sits directly downstream of the macro output decoder in layer3.
- Consumes the signed 4-bit decoded values for every channel of every macro.
- Sums them across the MACRO_NUM macros, then accumulates that sum over a programmable number of beats (kernel positions / input tiles).
- Presents one saturated signed partial sum per channel to the next stage through a valid/ready handshake.

---
 rtl/psum_accumulator.sv | 145 ++++++++++++++
 tb/tb_psum_accumulator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - sums decoded macro outputs per channel and accumulates them into saturated partial sums
module psum_accumulator #(
    parameter int CHANNEL_NUM = 128,
    parameter int MACRO_NUM   = 4,
    parameter int ACC_LEN_MAX = 16,
    parameter int OUT_WIDTH   = 12,
    localparam int LEN_W      = $clog2(ACC_LEN_MAX) + 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [3:0]           data_in [CHANNEL_NUM-1:0][MACRO_NUM-1:0],
    input  logic [LEN_W-1:0]            acc_len,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data [CHANNEL_NUM-1:0],
    output logic [CHANNEL_NUM-1:0]      out_sat
);

    localparam int SUM_W = 4 + $clog2(MACRO_NUM);
    localparam int ACC_W = SUM_W + $clog2(ACC_LEN_MAX);

    typedef enum logic {IDLE, ACC} state_t;

    state_t                     state_q, state_d;
    logic [LEN_W-1:0]           cnt_q;
    logic [LEN_W-1:0]           len_q;
    logic [LEN_W-1:0]           len_clamped;
    logic                       is_final;
    logic                       accept;
    logic signed [ACC_W-1:0]    acc_q   [CHANNEL_NUM];
    logic signed [ACC_W-1:0]    acc_sum [CHANNEL_NUM];
    logic signed [OUT_WIDTH-1:0] sat_val [CHANNEL_NUM];
    logic                       clip    [CHANNEL_NUM];

    // Clamp the requested length into 1..ACC_LEN_MAX; only used on a group's first beat
    always_comb begin
        len_clamped = acc_len;
        if (acc_len == '0)
            len_clamped = LEN_W'(1);
        else if (acc_len > LEN_W'(ACC_LEN_MAX))
            len_clamped = LEN_W'(ACC_LEN_MAX);
    end

    // Final-beat detection and back-pressure: only a final beat can be blocked by a stalled output
    always_comb begin
        if (state_q == IDLE)
            is_final = (len_clamped == LEN_W'(1));
        else
            is_final = (cnt_q == len_q - LEN_W'(1));
        in_ready = !(is_final && out_valid && !out_ready);
        accept   = in_valid && in_ready;
    end

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
        logic signed [SUM_W-1:0] beat_sum;
        logic signed [ACC_W-1:0] total;

        // Sign-extended sum of this channel across all macros
        always_comb begin
            beat_sum = '0;
            for (int m = 0; m < MACRO_NUM; m++)
                beat_sum = beat_sum + SUM_W'(data_in[c][m]);
        end

        assign total      = acc_q[c] + ACC_W'(beat_sum);
        assign acc_sum[c] = total;

        if (OUT_WIDTH >= ACC_W) begin : g_wide
            assign sat_val[c] = OUT_WIDTH'(total);
            assign clip[c]    = 1'b0;
        end else begin : g_narrow
            localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_WIDTH - 1)) - 1);
            localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

            // Clip the running total into the output range and flag it
            always_comb begin
                sat_val[c] = total[OUT_WIDTH-1:0];
                clip[c]    = 1'b0;
                if (total > SAT_MAX) begin
                    sat_val[c] = SAT_MAX[OUT_WIDTH-1:0];
                    clip[c]    = 1'b1;
                end else if (total < SAT_MIN) begin
                    sat_val[c] = SAT_MIN[OUT_WIDTH-1:0];
                    clip[c]    = 1'b1;
                end
            end
        end
    end

    // Group state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state: leave IDLE on a non-final first beat, return on the final beat
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (is_final)
                state_d = IDLE;
            else
                state_d = ACC;
        end
    end

    // Accumulators, beat counter, latched length and the output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            len_q     <= LEN_W'(1);
            out_valid <= 1'b0;
            out_sat   <= '0;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                acc_q[c]    <= '0;
                out_data[c] <= '0;
            end
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                if (state_q == IDLE)
                    len_q <= len_clamped;
                if (is_final) begin
                    out_valid <= 1'b1;
                    cnt_q     <= '0;
                    for (int c = 0; c < CHANNEL_NUM; c++) begin
                        out_data[c] <= sat_val[c];
                        out_sat[c]  <= clip[c];
                        acc_q[c]    <= '0;
                    end
                end else begin
                    cnt_q <= cnt_q + LEN_W'(1);
                    for (int c = 0; c < CHANNEL_NUM; c++)
                        acc_q[c] <= acc_sum[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - scoreboard bench for psum_accumulator
module tb_psum_accumulator;

    localparam int CH = 128;
    localparam int MN = 4;

    typedef struct {
        int   d0;
        int   drest;
        logic s0;
        logic srest;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic in_valid_a, in_valid_b;
    logic in_ready_a, in_ready_b;
    logic signed [3:0] din [CH-1:0][MN-1:0];
    logic [4:0] acc_len;
    logic out_valid_a, out_valid_b;
    logic out_ready;
    logic signed [11:0] oda [CH-1:0];
    logic signed [7:0]  odb [CH-1:0];
    logic [CH-1:0] osa, osb;

    int compared = 0;
    int mismatched = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    psum_accumulator u_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .data_in(din), .acc_len(acc_len), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(oda), .out_sat(osa)
    );

    psum_accumulator #(.OUT_WIDTH(8)) u_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .data_in(din), .acc_len(acc_len), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(odb), .out_sat(osb)
    );

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input int got [CH], input logic [CH-1:0] sat);
        int bad_d;
        int bad_s;
        bad_d = -1;
        bad_s = -1;
        for (int c = 0; c < CH; c++) begin
            if (bad_d < 0 && got[c] != ((c == 0) ? e.d0 : e.drest)) bad_d = c;
            if (bad_s < 0 && sat[c] != ((c == 0) ? e.s0 : e.srest)) bad_s = c;
        end
        compared += 2;
        if (bad_d >= 0) begin
            mismatched++;
            $display("FAIL %s_data ch%0d: got %0d, expected %0d", tag, bad_d, got[bad_d],
                     (bad_d == 0) ? e.d0 : e.drest);
        end
        if (bad_s >= 0) begin
            mismatched++;
            $display("FAIL %s_sat ch%0d: got %0b, expected %0b", tag, bad_s, sat[bad_s],
                     (bad_s == 0) ? e.s0 : e.srest);
        end
    endtask

    // Monitor for the default-width instance
    always @(negedge clk) begin
        if (rstn && out_valid_a && out_ready) begin
            int g [CH];
            for (int c = 0; c < CH; c++) g[c] = int'(oda[c]);
            if (qa.size() == 0) check("unexpected_out_a", 1, 0);
            else check_out("out_a", qa.pop_front(), g, osa);
        end
    end

    // Monitor for the 8-bit output instance
    always @(negedge clk) begin
        if (rstn && out_valid_b && out_ready) begin
            int g [CH];
            for (int c = 0; c < CH; c++) g[c] = int'(odb[c]);
            if (qb.size() == 0) check("unexpected_out_b", 1, 0);
            else check_out("out_b", qb.pop_front(), g, osb);
        end
    end

    task automatic fill(input int v);
        for (int c = 0; c < CH; c++)
            for (int m = 0; m < MN; m++)
                din[c][m] = 4'(v);
    endtask

    task automatic push_a(input int d0, input int dr, input logic s0, input logic sr);
        exp_t e;
        e.d0 = d0; e.drest = dr; e.s0 = s0; e.srest = sr;
        qa.push_back(e);
    endtask

    task automatic push_b(input int d0, input int dr, input logic s0, input logic sr);
        exp_t e;
        e.d0 = d0; e.drest = dr; e.s0 = s0; e.srest = sr;
        qb.push_back(e);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit to_b);
        int n;
        n = 0;
        if (to_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        @(negedge clk);
        while (!(to_b ? in_ready_b : in_ready_a) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        out_ready = 1'b1;
        acc_len = 5'd1;
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready_a), 1);
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_out_data0", int'(oda[0]), 0);
        check("rst_out_sat", int'(osa != '0), 0);
        rstn = 1'b1;
        idle(1);

        // Basic group: 9 beats of beat_sum 28
        acc_len = 5'd9;
        fill(7);
        push_a(252, 252, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) check("basic_valid_before_last", int'(out_valid_a), 0);
            send(1'b0);
        end
        check("basic_latency_valid", int'(out_valid_a), 1);
        idle(2);

        // Saturation on the 8-bit instance
        acc_len = 5'd16;
        fill(-8);
        push_b(-128, -128, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) send(1'b1);
        idle(2);
        fill(7);
        push_b(127, 127, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) send(1'b1);
        idle(2);

        // Mixed macros on channel 0, length 1 and clamped length 0
        fill(1);
        din[0][0] = 4'sd7; din[0][1] = -4'sd8; din[0][2] = 4'sd3; din[0][3] = -4'sd2;
        acc_len = 5'd1;
        push_a(0, 4, 1'b0, 1'b0);
        send(1'b0);
        check("len1_latency_valid", int'(out_valid_a), 1);
        idle(1);
        acc_len = 5'd0;
        push_a(0, 4, 1'b0, 1'b0);
        send(1'b0);
        check("len0_latency_valid", int'(out_valid_a), 1);
        idle(2);

        // Back-pressure: second group overlaps a stalled first result
        out_ready = 1'b0;
        acc_len = 5'd4;
        fill(1);
        push_a(16, 16, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(1'b0);
        fill(2);
        push_a(32, 32, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b0);
        in_valid_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", int'(in_ready_a), 0);
            check("bp_data_held", int'(oda[5]), 16);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", int'(in_ready_a), 1);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        check("bp_valid_kept", int'(out_valid_a), 1);
        check("bp_new_data", int'(oda[0]), 32);
        idle(2);

        // Bubbles inside a group and a length change that must be ignored
        acc_len = 5'd3;
        fill(1);
        push_a(12, 12, 1'b0, 1'b0);
        send(1'b0);
        acc_len = 5'd5;
        idle(2);
        send(1'b0);
        idle(2);
        send(1'b0);
        check("bubble_final_valid", int'(out_valid_a), 1);
        idle(2);

        // Reset mid-group with a stalled result pending
        out_ready = 1'b0;
        acc_len = 5'd1;
        fill(3);
        send(1'b0);
        acc_len = 5'd8;
        fill(7);
        for (int i = 0; i < 5; i++) send(1'b0);
        check("pre_rst_valid", int'(out_valid_a), 1);
        #3;
        rstn = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid_a), 0);
        check("async_rst_data", int'(oda[0]), 0);
        idle(1);
        rstn = 1'b1;
        out_ready = 1'b1;
        idle(1);
        acc_len = 5'd8;
        fill(1);
        push_a(32, 32, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send(1'b0);
        check("post_rst_valid", int'(out_valid_a), 1);

        begin
            int n;
            n = 0;
            while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
                n++;
                @(posedge clk);
            end
            #1;
            check("queue_a_drained", qa.size(), 0);
            check("queue_b_drained", qb.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
